// File: rtl/udp_checker_pkg.sv
// Shared types and constants for the UDP payload checker: FSM states,
// error-bit positions and the UDP header size used by the length check.
package udp_checker_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DROP  = 2'd2
   } state_e;

   localparam int unsigned ERR_SEQ  = 0;
   localparam int unsigned ERR_USER = 1;
   localparam int unsigned ERR_LEN  = 2;

   localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

   // A length field shorter than the header can never describe a valid packet.
   function automatic logic len_mismatch(input logic [15:0] udp_len,
                                         input logic [15:0] n_bytes);
      logic bad;
      if (udp_len < UDP_HDR_BYTES) begin
         bad = 1'b1;
      end else begin
         bad = (n_bytes != (udp_len - UDP_HDR_BYTES));
      end
      return bad;
   endfunction

endpackage

// File: rtl/udp_payload_checker_sat_counter.sv
// 32-bit event counter that holds at all-ones instead of wrapping.
module sat_counter (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q;

   // Count qualified events, holding once the maximum value is reached.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= 32'd0;
      end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end else begin
         count_q <= count_q;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/udp_payload_checker.sv
// Filters UDP packets by destination port and checks the payload is an
// incrementing byte sequence. Length check enabled by UDP_PAYLOAD_CHECKER_LEN_CHECK_EN.
module udp_payload_checker
   import udp_checker_pkg::*;
#(
   parameter logic [15:0] LISTEN_PORT = 16'd3000,
   parameter logic [7:0]  SEQ_INIT    = 8'd0
) (
   input  logic        udp_sys_clk,
   input  logic        system_reset,
   input  logic        udp_hdr_valid,
   output logic        udp_hdr_ready,
   input  logic [15:0] udp_dest_port,
   input  logic [15:0] udp_length,
   input  logic [7:0]  s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tlast,
   input  logic        s_tuser,
   output logic [31:0] pkt_count,
   output logic [31:0] drop_count,
   output logic [31:0] err_count,
   output logic [2:0]  last_err,
   output logic [7:0]  seq_expected
);

   state_e      state_q;
   logic        hdr_ready_q;
   logic        tready_q;
   logic [7:0]  seq_q;
   logic [2:0]  flags_q;
   logic [2:0]  last_err_q;

   logic        hdr_hs_s;
   logic        beat_s;
   logic        tlast_beat_s;
   logic [2:0]  beat_flags_s;
   logic [2:0]  pkt_flags_s;
   logic        pkt_inc_s;
   logic        drop_inc_s;
   logic        err_inc_s;

`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
   logic [15:0] len_q;
   logic [15:0] bcnt_q;
`else
   logic        unused_len_s;
   assign unused_len_s = ^udp_length;
`endif

   // Beat qualification and the error flags a packet would end with on this beat.
   always_comb begin
      hdr_hs_s     = udp_hdr_valid & hdr_ready_q;
      beat_s       = s_tvalid & tready_q;
      tlast_beat_s = beat_s & s_tlast;
      beat_flags_s = 3'b000;
      if ((state_q == CHECK) && beat_s) begin
         beat_flags_s[ERR_SEQ]  = (s_tdata != seq_q);
         beat_flags_s[ERR_USER] = s_tlast & s_tuser;
`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
         beat_flags_s[ERR_LEN]  = s_tlast & len_mismatch(len_q, bcnt_q + 16'd1);
`endif
      end else begin
         beat_flags_s = 3'b000;
      end
      pkt_flags_s = flags_q | beat_flags_s;
      pkt_inc_s   = (state_q == CHECK) & tlast_beat_s;
      drop_inc_s  = (state_q == DROP) & tlast_beat_s;
      err_inc_s   = pkt_inc_s & (pkt_flags_s != 3'b000);
   end

   // Packet FSM with its registered handshake outputs and per-packet state.
   always_ff @(posedge udp_sys_clk) begin
      if (system_reset) begin
         state_q     <= IDLE;
         hdr_ready_q <= 1'b0;
         tready_q    <= 1'b0;
         seq_q       <= SEQ_INIT;
         flags_q     <= 3'b000;
         last_err_q  <= 3'b000;
`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
         len_q       <= 16'd0;
         bcnt_q      <= 16'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               hdr_ready_q <= 1'b1;
               tready_q    <= 1'b0;
               if (hdr_hs_s) begin
                  hdr_ready_q <= 1'b0;
                  tready_q    <= 1'b1;
                  flags_q     <= 3'b000;
`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
                  len_q       <= udp_length;
                  bcnt_q      <= 16'd0;
`endif
                  state_q     <= (udp_dest_port == LISTEN_PORT) ? CHECK : DROP;
               end
            end
            CHECK: begin
               if (beat_s) begin
                  // Resynchronise on the received byte so one bad byte is one error.
                  seq_q   <= s_tdata + 8'd1;
                  flags_q <= pkt_flags_s;
`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
                  bcnt_q  <= bcnt_q + 16'd1;
`endif
                  if (s_tlast) begin
                     state_q     <= IDLE;
                     tready_q    <= 1'b0;
                     hdr_ready_q <= 1'b1;
                     if (err_inc_s) begin
                        last_err_q <= pkt_flags_s;
                     end
                  end
               end
            end
            DROP: begin
               if (tlast_beat_s) begin
                  state_q     <= IDLE;
                  tready_q    <= 1'b0;
                  hdr_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               hdr_ready_q <= 1'b0;
               tready_q    <= 1'b0;
            end
         endcase
      end
   end

   sat_counter u_pkt_cnt (
      .clk_i   (udp_sys_clk),
      .rst_i   (system_reset),
      .inc_i   (pkt_inc_s),
      .count_o (pkt_count)
   );

   sat_counter u_drop_cnt (
      .clk_i   (udp_sys_clk),
      .rst_i   (system_reset),
      .inc_i   (drop_inc_s),
      .count_o (drop_count)
   );

   sat_counter u_err_cnt (
      .clk_i   (udp_sys_clk),
      .rst_i   (system_reset),
      .inc_i   (err_inc_s),
      .count_o (err_count)
   );

   assign udp_hdr_ready = hdr_ready_q;
   assign s_tready      = tready_q;
   assign last_err      = last_err_q;
   assign seq_expected  = seq_q;

endmodule

// File: tb/tb_udp_payload_checker.sv
// Self-checking bench for udp_payload_checker: directed scenarios plus
// randomized packets checked against a packet-level reference model.
module tb_udp_payload_checker;

   logic        udp_sys_clk = 1'b0;
   logic        system_reset = 1'b1;
   logic        udp_hdr_valid = 1'b0;
   logic        udp_hdr_ready;
   logic [15:0] udp_dest_port = 16'd0;
   logic [15:0] udp_length = 16'd0;
   logic [7:0]  s_tdata = 8'd0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tlast = 1'b0;
   logic        s_tuser = 1'b0;
   logic [31:0] pkt_count;
   logic [31:0] drop_count;
   logic [31:0] err_count;
   logic [2:0]  last_err;
   logic [7:0]  seq_expected;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state
   int unsigned m_pkt, m_drop, m_err;
   logic [2:0]  m_last_err;
   logic [7:0]  m_seq;

   logic [7:0]  pbytes [0:299];

   udp_payload_checker dut (
      .udp_sys_clk   (udp_sys_clk),
      .system_reset  (system_reset),
      .udp_hdr_valid (udp_hdr_valid),
      .udp_hdr_ready (udp_hdr_ready),
      .udp_dest_port (udp_dest_port),
      .udp_length    (udp_length),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tlast       (s_tlast),
      .s_tuser       (s_tuser),
      .pkt_count     (pkt_count),
      .drop_count    (drop_count),
      .err_count     (err_count),
      .last_err      (last_err),
      .seq_expected  (seq_expected)
   );

   always #5 udp_sys_clk = ~udp_sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pkt = 0; m_drop = 0; m_err = 0; m_last_err = 3'b000; m_seq = 8'h00;
   endtask

   task automatic model_pkt(input logic [15:0] port, input logic [15:0] len,
                            input int nb, input bit user);
      logic [2:0] fl;
      int         expect_bytes;
      if (port != 16'd3000) begin
         m_drop++;
         return;
      end
      fl = 3'b000;
      for (int i = 0; i < nb; i++) begin
         if (pbytes[i] != m_seq) fl[0] = 1'b1;
         m_seq = pbytes[i] + 8'd1;
      end
      if (user) fl[1] = 1'b1;
`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
      expect_bytes = int'(len) - 8;
      if (expect_bytes < 0 || nb != expect_bytes) fl[2] = 1'b1;
`else
      expect_bytes = int'(len);
`endif
      m_pkt++;
      if (fl != 3'b000) begin
         m_err++;
         m_last_err = fl;
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".pkt"},   pkt_count,  m_pkt);
      check_eq({tag, ".drop"},  drop_count, m_drop);
      check_eq({tag, ".err"},   err_count,  m_err);
      check_eq({tag, ".last"},  {29'd0, last_err},     {29'd0, m_last_err});
      check_eq({tag, ".seq"},   {24'd0, seq_expected}, {24'd0, m_seq});
      check_eq({tag, ".hrdy"},  {31'd0, udp_hdr_ready}, 32'd1);
      check_eq({tag, ".trdy"},  {31'd0, s_tready},      32'd0);
   endtask

   task automatic check_in_reset(input string tag);
      check_eq({tag, ".rst_hrdy"}, {31'd0, udp_hdr_ready}, 32'd0);
      check_eq({tag, ".rst_trdy"}, {31'd0, s_tready},      32'd0);
      check_eq({tag, ".rst_pkt"},  pkt_count,  32'd0);
      check_eq({tag, ".rst_drop"}, drop_count, 32'd0);
      check_eq({tag, ".rst_err"},  err_count,  32'd0);
      check_eq({tag, ".rst_last"}, {29'd0, last_err},     32'd0);
      check_eq({tag, ".rst_seq"},  {24'd0, seq_expected}, 32'd0);
   endtask

   // Called at a negedge with system_reset high; releases it and checks recovery.
   task automatic release_reset(input string tag);
      system_reset = 1'b0;
      @(negedge udp_sys_clk);
      model_reset();
      compare_all({tag, ".post_rst"});
   endtask

   task automatic do_reset(input string tag);
      @(negedge udp_sys_clk);
      system_reset  = 1'b1;
      udp_hdr_valid = 1'b0;
      s_tvalid      = 1'b0;
      repeat (2) @(posedge udp_sys_clk);
      @(negedge udp_sys_clk);
      check_in_reset(tag);
      release_reset(tag);
   endtask

   // Sends one packet from pbytes; abort_at >= 0 asserts reset on that beat.
   task automatic send_pkt(input logic [15:0] port, input logic [15:0] len,
                           input int nb, input bit user, input int abort_at);
      int n;
      n = 0;
      while (!udp_hdr_ready && n < 50) begin
         @(negedge udp_sys_clk);
         n++;
      end
      check_eq("hdr_ready_wait", {31'd0, udp_hdr_ready}, 32'd1);
      udp_hdr_valid = 1'b1;
      udp_dest_port = port;
      udp_length    = len;
      @(posedge udp_sys_clk);
      @(negedge udp_sys_clk);
      udp_hdr_valid = 1'b0;
      udp_dest_port = 16'($urandom);
      udp_length    = 16'($urandom);
      for (int i = 0; i < nb; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge udp_sys_clk);
         n = 0;
         while (!s_tready && n < 20) begin
            @(negedge udp_sys_clk);
            n++;
         end
         check_eq("tready_wait", {31'd0, s_tready}, 32'd1);
         s_tdata  = pbytes[i];
         s_tvalid = 1'b1;
         s_tlast  = (i == nb - 1);
         s_tuser  = (i == nb - 1) ? user : 1'($urandom);
         if (i == abort_at) system_reset = 1'b1;
         @(posedge udp_sys_clk);
         @(negedge udp_sys_clk);
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         s_tuser  = 1'b0;
         if (i == abort_at) return;
      end
      model_pkt(port, len, nb, user);
   endtask

   task automatic send_single(input logic [7:0] b, input bit user);
      pbytes[0] = b;
      send_pkt(16'd3000, 16'd9, 1, user, -1);
   endtask

   initial begin
      logic [7:0] r_seq;
      logic [15:0] port, len;
      int nb;
      bit user;

      model_reset();
      do_reset("init");

      // Ten in-order single-byte packets
      for (int i = 0; i < 10; i++) send_single(8'(i), 1'b0);
      check_eq("seq10.pkt", pkt_count, 32'd10);
      check_eq("seq10.err", err_count, 32'd0);
      check_eq("seq10.seq", {24'd0, seq_expected}, 32'h0A);
      compare_all("seq10");

      // Gap in the sequence, then resynchronised
      do_reset("gap");
      send_single(8'h00, 1'b0);
      send_single(8'h01, 1'b0);
      send_single(8'h05, 1'b0);
      send_single(8'h06, 1'b0);
      check_eq("gap.err",  err_count, 32'd1);
      check_eq("gap.last", {29'd0, last_err}, 32'd1);
      check_eq("gap.seq",  {24'd0, seq_expected}, 32'h07);
      compare_all("gap");

      // Wrong destination port is dropped
      do_reset("drop");
      for (int i = 0; i < 4; i++) pbytes[i] = 8'h55 + 8'(i);
      send_pkt(16'd3001, 16'd12, 4, 1'b0, -1);
      check_eq("drop.drop", drop_count, 32'd1);
      check_eq("drop.pkt",  pkt_count,  32'd0);
      check_eq("drop.seq",  {24'd0, seq_expected}, 32'h00);
      compare_all("drop");

      // Length field says 4 payload bytes, only 3 sent
      do_reset("len");
      for (int i = 0; i < 3; i++) pbytes[i] = 8'(i);
      send_pkt(16'd3000, 16'd12, 3, 1'b0, -1);
`ifdef UDP_PAYLOAD_CHECKER_LEN_CHECK_EN
      check_eq("len.last", {29'd0, last_err}, 32'd4);
      check_eq("len.err",  err_count, 32'd1);
`else
      check_eq("len.last", {29'd0, last_err}, 32'd0);
      check_eq("len.err",  err_count, 32'd0);
`endif
      compare_all("len");

      // Sequence wrap FF->00 is clean; frame error flagged on the next packet
      do_reset("wrap");
      for (int i = 0; i < 254; i++) pbytes[i] = 8'(i);
      send_pkt(16'd3000, 16'd262, 254, 1'b0, -1);
      send_single(8'hFE, 1'b0);
      send_single(8'hFF, 1'b0);
      send_single(8'h00, 1'b0);
      check_eq("wrap.err0", err_count, 32'd0);
      send_single(8'h01, 1'b1);
      check_eq("wrap.last", {29'd0, last_err}, 32'd2);
      check_eq("wrap.err",  err_count, 32'd1);
      compare_all("wrap");

      // Reset in the middle of a packet
      do_reset("abort");
      send_single(8'h00, 1'b0);
      for (int i = 0; i < 4; i++) pbytes[i] = 8'(i + 1);
      send_pkt(16'd3000, 16'd12, 4, 1'b0, 1);
      @(posedge udp_sys_clk);
      @(negedge udp_sys_clk);
      check_in_reset("abort");
      release_reset("abort");

      // Randomized traffic against the model
      do_reset("rand");
      r_seq = 8'h00;
      for (int p = 0; p < 60; p++) begin
         nb = $urandom_range(1, 6);
         for (int i = 0; i < nb; i++) begin
            pbytes[i] = ($urandom_range(0, 6) == 0) ? 8'($urandom) : r_seq;
            r_seq = pbytes[i] + 8'd1;
         end
         if ($urandom_range(0, 4) == 0) begin
            port = 16'($urandom);
            if (port == 16'd3000) port = 16'd3001;
         end else begin
            port = 16'd3000;
         end
         len  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'(nb + 8);
         user = ($urandom_range(0, 9) == 0);
         send_pkt(port, len, nb, user, -1);
         compare_all("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/udp_payload_checker.md
UDP_PAYLOAD_CHECKER -- requirements
Module: udp_payload_checker

Interface
REQ-001 The block SHALL have parameter LISTEN_PORT, default 16'd3000, the UDP destination port accepted; other ports are dropped.
REQ-002 The block SHALL have parameter SEQ_INIT, default 8'd0, the expected first payload byte after reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with the ports listed as follows.
- udp_sys_clk  in  1  sole clock; all logic on rising edge.
- system_reset  in  1  synchronous, active-high reset.
- udp_hdr_valid  in  1  header valid.
- udp_hdr_ready  out  1  header ready.
- udp_dest_port  in  16  header destination port.
- udp_length  in  16  UDP length (header plus payload, bytes).
- s_tdata  in  8  payload byte.
- s_tvalid  in  1  payload valid.
- s_tready  out  1  payload ready.
- s_tlast  in  1  last payload byte of packet.
- s_tuser  in  1  frame error flag; sampled on the tlast beat.
- pkt_count  out  32  accepted packets checked.
- drop_count  out  32  packets dropped by port filter.
- err_count  out  32  packets with at least one error.
- last_err  out  3  sticky error bits {len, user, seq} of the most recent errored packet.
- seq_expected  out  8  next expected payload byte.

Function
REQ-004 The FSM SHALL have the states IDLE, CHECK and DROP.
REQ-005 IDLE: udp_hdr_ready=1 and s_tready=0; on a header handshake, latch udp_length; go to CHECK if udp_dest_port==LISTEN_PORT, else go to DROP.
REQ-006 CHECK/DROP: udp_hdr_ready=0 and s_tready=1; every beat with s_tvalid&&s_tready SHALL be consumed.
REQ-007 In CHECK, each beat SHALL compare s_tdata with seq_expected; on a mismatch set the per-packet seq flag.
REQ-008 seq_expected SHALL advance to s_tdata+1 (mod 256) on every CHECK beat, so the sequence resynchronises after an error; 8'hFF SHALL wrap to 8'h00 without an error.
REQ-009 In CHECK, a 16-bit byte counter SHALL count beats, starting at 1 on the first beat.
REQ-010 On the tlast beat, if count != latched udp_length-8, set the len flag; a udp_length below 8 SHALL always flag len.
REQ-011 On the tlast beat, s_tuser=1 SHALL set the user flag.
REQ-012 The cycle after a CHECK tlast beat: pkt_count SHALL increment; if any flag is set, err_count SHALL increment once and last_err SHALL be loaded with the flags; then the FSM SHALL return to IDLE.
REQ-013 The cycle after a DROP tlast beat: drop_count SHALL increment and the FSM SHALL return to IDLE; seq_expected SHALL be unchanged.
REQ-014 All counters SHALL saturate at 32'hFFFF_FFFF.
REQ-015 Per-packet flags and the byte counter SHALL clear on entry to CHECK.
REQ-016 A header handshake and a payload beat cannot occur in the same cycle, because the ready outputs are mutually exclusive.

Reset
REQ-017 During reset: state=IDLE, all counters=0, last_err=0, seq_expected=SEQ_INIT, s_tready=0, udp_hdr_ready=0; udp_hdr_ready SHALL rise the first cycle after reset deasserts.
REQ-018 Reset asserted mid-packet SHALL abandon the packet with no count update; the remaining beats of that packet arriving after reset SHALL be treated as fresh stream input, and the source is responsible for flushing them.

Configuration
REQ-019 The macro UDP_PAYLOAD_CHECKER_LEN_CHECK_EN SHALL control the length check.
- Defined: the length check (REQ-010) is compiled in.
- Undefined: the length check is compiled out, the len flag and last_err[2] are tied 0, and the udp_length latch and byte counter are omitted.

Structure
REQ-020 Package udp_checker_pkg SHALL hold the FSM state enum, the error-bit indices (SEQ=0, USER=1, LEN=2) and UDP_HDR_BYTES=8.
REQ-021 The saturating 32-bit counter SHALL be the sub-module sat_counter, instantiated three times.

Verification
REQ-022 Single-byte packets 0x00..0x09 to port 3000, udp_length=9 -> pkt_count=10, err_count=0, seq_expected=0x0A.
REQ-023 Stream 0x00,0x01,0x05,0x06 as four single-byte packets -> err_count=1, last_err=3'b001, seq_expected=0x07.
REQ-024 Header to port 3001 plus 4 bytes -> drop_count=1, pkt_count=0, seq_expected unchanged.
REQ-025 udp_length=12 with 3 payload bytes -> last_err=3'b100 with the macro defined; last_err=3'b000 and err_count=0 with it undefined.
REQ-026 Bytes 0xFE,0xFF,0x00 across three packets, then s_tuser=1 on the next tlast -> no seq error at the wrap; last_err=3'b010 and err_count=1.
REQ-027 Reset asserted on the 2nd of 4 bytes -> all counters=0, state=IDLE, and udp_hdr_ready=1 one cycle after reset deasserts.
